// File: rtl/dataflow_rx.sv
// dataflow_rx: UART-style serial receiver.
// The frame is idle high, a start 0, n data bits LSB first, an optional parity bit and a stop 1.
// The optional macro RX_INPUT_SYNC_EN adds a two-flop synchronizer on Rx.
// The synchronizer delays every sample point by two cycles relative to the pin.
//
// state  | meaning
// IDLE   | line idle, waiting for a 0 sample (start edge)
// START  | half a bit in, confirm the start bit is still 0
// DATA   | sample n data bits at bit centres, LSB first
// PARITY | sample the parity bit (only if parity was latched on)
// STOP   | sample the stop bit, then report the frame
// BREAK  | stop bit was 0; wait for the line to go high again
module dataflow_rx #(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Rx,
  input  logic         parity_check,
  input  logic         parity_type_even_odd,
  output logic [n-1:0] Q,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(n - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bit_idx;
  logic [n-1:0]   shreg;
  logic [n-1:0]   shift_nxt;
  logic           par_acc;
  logic           par_en_q;
  logic           par_even_q;
  logic           perr_q;
  logic           rx_s;
  logic           tick;
  logic           load_half;
  logic           load_full;
  logic           shift_en;
  logic           par_sample;
  logic           stop_sample;

`ifdef RX_INPUT_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], Rx};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = Rx;
`endif

  assign tick = (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; every sample point is the terminal count of the bit timer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (tick && (bit_idx == LAST_BIT)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes decoded from state and the timer.
  always_comb begin
    load_half   = 1'b0;
    load_full   = 1'b0;
    shift_en    = 1'b0;
    par_sample  = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE:   load_half = !rx_s;
      START:  load_full = tick;
      DATA: begin
        load_full = tick;
        shift_en  = tick;
      end
      PARITY: begin
        load_full  = tick;
        par_sample = tick;
      end
      STOP:   stop_sample = tick;
      default: ;
    endcase
  end

  // Shift register with the next sampled bit placed in the MSB.
  always_comb begin
    shift_nxt        = shreg >> 1;
    shift_nxt[n-1]   = rx_s;
  end

  // Bit timer, bit index, shift register and parity accumulation.
  // Frame options are captured at the start edge so that later changes cannot affect the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (load_half)        cnt <= HALF_LOAD;
      else if (load_full)   cnt <= FULL_LOAD;
      else if (cnt != '0)   cnt <= cnt - 1'b1;

      if (load_half) begin
        bit_idx    <= '0;
        par_acc    <= 1'b0;
        perr_q     <= 1'b0;
        par_en_q   <= parity_check;
        par_even_q <= parity_type_even_odd;
      end else begin
        if (shift_en) begin
          shreg   <= shift_nxt;
          par_acc <= par_acc ^ rx_s;
          if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 1'b1;
        end
        if (par_sample)
          perr_q <= par_even_q ? (par_acc ^ rx_s) : ~(par_acc ^ rx_s);
      end
    end
  end

  // Frame report: one-cycle valid, with Q and the flags held until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      Q          <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= stop_sample;
      if (stop_sample) begin
        Q          <= shreg;
        parity_err <= par_en_q & perr_q;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_dataflow_rx.sv
// Testbench for dataflow_rx using directed frames and a scoreboard queue.
// The monitor compares every valid pulse against the next expected frame, including its arrival cycle.
module tb_dataflow_rx;

  localparam int N   = 8;
  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         Rx;
  logic         parity_check;
  logic         parity_type_even_odd;
  logic [N-1:0] Q;
  logic         valid;
  logic         parity_err;
  logic         frame_err;

  typedef struct {
    logic [N-1:0] q;
    logic         perr;
    logic         ferr;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  dataflow_rx #(.n(N), .CLKS_PER_BIT(CPB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Rx                   (Rx),
    .parity_check         (parity_check),
    .parity_type_even_odd (parity_type_even_odd),
    .Q                    (Q),
    .valid                (valid),
    .parity_err           (parity_err),
    .frame_err            (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each valid pulse is compared with the oldest expected frame.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("q", int'(Q), int'(e.q));
        check("parity_err", int'(parity_err), int'(e.perr));
        check("frame_err", int'(frame_err), int'(e.ferr));
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic hold_bit(input logic v);
    Rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends a frame and hands the expected report to the scoreboard.
  // The parity inputs are inverted after the start bit; the frame must keep the values seen at the start edge.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic even,
                            input logic pbit, input logic stop_bit,
                            input logic eperr, input logic eferr);
    exp_t e;
    e.q    = data;
    e.perr = eperr;
    e.ferr = eferr;
    e.cyc  = cyc + 1 + CPB / 2 + (N + (pen ? 1 : 0) + 1) * CPB;
    exp_q.push_back(e);
    parity_check         = pen;
    parity_type_even_odd = even;
    hold_bit(1'b0);
    parity_check         = ~pen;
    parity_type_even_odd = ~even;
    for (int k = 0; k < N; k++) hold_bit(data[k]);
    if (pen) hold_bit(pbit);
    hold_bit(stop_bit);
  endtask

  task automatic idle(input int cycles);
    Rx = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected frames left %0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] part;
    rst = 1'b1;
    Rx = 1'b1;
    parity_check = 1'b0;
    parity_type_even_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_q", int'(Q), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_perr", int'(parity_err), 0);
    check("reset_ferr", int'(frame_err), 0);

    // 0xA5 has even weight, so a 0 parity bit passes in even mode and fails in odd mode.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // A bad stop bit followed by a long low line: one report, then silence until the line is high again.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    Rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(4);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // A one-cycle low glitch is a false start and produces no report.
    Rx = 1'b0;
    @(posedge clk);
    #1;
    idle(10);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back frames with no idle gap between the stop bit and the next start bit.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset during data bit 4 discards the partial frame and clears the outputs.
    part = 8'h96;
    parity_check = 1'b0;
    hold_bit(1'b0);
    for (int k = 0; k < 4; k++) hold_bit(part[k]);
    Rx = part[4];
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    Rx = 1'b1;
    check("midrst_q", int'(Q), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_perr", int'(parity_err), 0);
    check("midrst_ferr", int'(frame_err), 0);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);

    check("frames_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
